// File: rtl/spike_event_fifo_if.sv
// Byte stream carrying framed spike events out of spike_event_fifo.
// The master drives valid/data and the slave drives ready.
interface spike_event_fifo_if;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/spike_event_fifo.sv
// Timestamps pre/post spike edges, buffers them and streams each as a two-byte frame.
// Optional build macro SPIKE_EVENT_DROP_CNT_EN adds the saturating drop_count output.
module spike_event_fifo #(
  parameter int TS_WIDTH = 12,
  parameter int DEPTH    = 8,
  parameter int PRESCALE = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     spike_pre,
  input  logic                     spike_post,
  spike_event_fifo_if.master       out_if,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef SPIKE_EVENT_DROP_CNT_EN
  ,
  output logic [7:0]               drop_count
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int EW  = TS_WIDTH + 2;
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0]      PRESC_MAX = PSW'(PRESCALE - 1);
  localparam logic [PSW-1:0]      PRESC_ONE = PSW'(1);
  localparam logic [TS_WIDTH-1:0] TS_ONE    = TS_WIDTH'(1);
  localparam logic [TS_WIDTH-1:0] TS_MAX    = '1;
  localparam logic [AW:0]         PTR_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HI = 2'd1, ST_LO = 2'd2} state_t;

  logic [PSW-1:0]      presc_r;
  logic [TS_WIDTH-1:0] ts_r;
  logic [1:0]          spike_q_r;
  logic                wrap_pend_r;
  logic [EW-1:0]       mem_r [DEPTH];
  logic [AW:0]         wr_ptr_r;
  logic [AW:0]         rd_ptr_r;
  logic [AW:0]         count_r;
  logic                overflow_r;
  state_t              state_r;
  logic [6:0]          ev_lo_r;
  logic                out_valid_r;
  logic [7:0]          out_data_r;

  logic [1:0]          edge_s;
  logic                spike_ev_s;
  logic                empty_s;
  logic                full_s;
  logic                pop_s;
  logic                room_s;
  logic                tick_s;
  logic                push_s;
  logic                drop_s;
  logic                marker_s;
  logic [EW-1:0]       wr_data_s;
  logic [EW-1:0]       rd_ev_s;

  assign edge_s     = {spike_post, spike_pre} & ~spike_q_r;
  assign spike_ev_s = enable & (|edge_s);
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s      = !empty_s && ((state_r == ST_IDLE) || ((state_r == ST_LO) && out_if.out_ready));
  assign room_s     = !full_s || pop_s;
  assign tick_s     = enable && (presc_r == PRESC_MAX);
  assign rd_ev_s    = mem_r[rd_ptr_r[AW-1:0]];

  // Write arbitration: a spike event wins; the wrap marker waits for a free slot.
  always_comb begin
    push_s    = 1'b0;
    drop_s    = 1'b0;
    marker_s  = 1'b0;
    wr_data_s = '0;
    if (spike_ev_s) begin
      wr_data_s = {edge_s, ts_r};
      if (room_s) begin
        push_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else if (wrap_pend_r && room_s) begin
      push_s   = 1'b1;
      marker_s = 1'b1;
    end else begin
      push_s   = 1'b0;
    end
  end

  // Edge history, prescaler, timestamp and pending wrap marker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r     <= '0;
      ts_r        <= '0;
      spike_q_r   <= 2'b00;
      wrap_pend_r <= 1'b0;
    end else begin
      spike_q_r <= {spike_post, spike_pre};
      if (tick_s) begin
        presc_r <= '0;
        ts_r    <= ts_r + TS_ONE;
      end else if (enable) begin
        presc_r <= presc_r + PRESC_ONE;
      end else begin
        presc_r <= presc_r;
      end
      if (tick_s && (ts_r == TS_MAX)) begin
        wrap_pend_r <= 1'b1;
      end else if (marker_s) begin
        wrap_pend_r <= 1'b0;
      end else begin
        wrap_pend_r <= wrap_pend_r;
      end
    end
  end

  // Circular buffer storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wr_data_s;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + PTR_ONE;
        2'b01:   count_r <= count_r - PTR_ONE;
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Output framer: header byte {1,src,ts[11:7]} then low byte {0,ts[6:0]}.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      ev_lo_r     <= 7'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            ev_lo_r     <= rd_ev_s[6:0];
            out_data_r  <= {1'b1, rd_ev_s[EW-1:EW-2], rd_ev_s[11:7]};
            out_valid_r <= 1'b1;
            state_r     <= ST_HI;
          end else begin
            out_data_r  <= 8'd0;
            out_valid_r <= 1'b0;
          end
        end
        ST_HI: begin
          if (out_if.out_ready) begin
            out_data_r <= {1'b0, ev_lo_r};
            state_r    <= ST_LO;
          end else begin
            out_data_r <= out_data_r;
          end
        end
        ST_LO: begin
          if (out_if.out_ready && pop_s) begin
            ev_lo_r    <= rd_ev_s[6:0];
            out_data_r <= {1'b1, rd_ev_s[EW-1:EW-2], rd_ev_s[11:7]};
            state_r    <= ST_HI;
          end else if (out_if.out_ready) begin
            out_data_r  <= 8'd0;
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            out_data_r <= out_data_r;
          end
        end
        default: begin
          out_data_r  <= 8'd0;
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SPIKE_EVENT_DROP_CNT_EN
  logic [7:0] drop_cnt_r;

  // Saturating count of dropped events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_count = drop_cnt_r;
`endif

  assign out_if.out_valid = out_valid_r;
  assign out_if.out_data  = out_data_r;
  assign overflow         = overflow_r;
  assign fifo_count       = count_r;

endmodule

// File: tb/tb_spike_event_fifo.sv
// Scoreboard bench for spike_event_fifo: a queue-based event model predicts frames,
// occupancy and overflow; a negedge monitor compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_spike_event_fifo;
  localparam int DEPTH    = 8;
  localparam int PRESCALE = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       spike_pre = 1'b0;
  logic       spike_post = 1'b0;
  logic       overflow;
  logic [3:0] fifo_count;
`ifdef SPIKE_EVENT_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  spike_event_fifo_if bus();

  spike_event_fifo #(.TS_WIDTH(12), .DEPTH(DEPTH), .PRESCALE(PRESCALE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .spike_pre  (spike_pre),
    .spike_post (spike_post),
    .out_if     (bus),
    .overflow   (overflow),
    .fifo_count (fifo_count)
`ifdef SPIKE_EVENT_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int max_cnt = 0;

  // Reference model state
  logic [13:0] m_fifo[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          m_stage = 0;     // 0 idle, 1 header shown, 2 low byte shown
  int unsigned m_en = 0;        // enabled clock cycles since reset
  bit          m_wrap = 1'b0;
  bit          m_ovf = 1'b0;
  int          m_drops = 0;
  logic [1:0]  m_sq = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_event(input logic [13:0] ev);
    m_fifo.push_back(ev);
    exp_q.push_back({1'b1, ev[13:12], ev[11:7]});
    exp_q.push_back({1'b0, ev[6:0]});
  endtask

  task automatic model_step();
    logic [1:0]  e;
    logic [11:0] ts;
    bit          room;
    if (!reset_n) begin
      m_fifo.delete();
      exp_q.delete();
      m_stage = 0; m_en = 0; m_wrap = 1'b0; m_ovf = 1'b0; m_drops = 0; m_sq = 2'b00;
      return;
    end
    if (m_stage == 1 && bus.out_ready) m_stage = 2;
    else if (m_stage == 2 && bus.out_ready) m_stage = 0;
    if (m_stage == 0 && m_fifo.size() > 0) begin
      void'(m_fifo.pop_front());
      m_stage = 1;
    end
    e    = {spike_post, spike_pre} & ~m_sq;
    m_sq = {spike_post, spike_pre};
    ts   = 12'((m_en / PRESCALE) % 4096);
    room = (m_fifo.size() < DEPTH);
    if (enable && e != 2'b00) begin
      if (room) push_event({e, ts});
      else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end else if (m_wrap && room) begin
      push_event(14'd0);
      m_wrap = 1'b0;
    end
    if (enable) begin
      m_en++;
      if (m_en % (PRESCALE * 4096) == 0) m_wrap = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compare the presented byte/occupancy against the model
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_data", 32'(bus.out_data), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
    end else begin
      chk("valid", 32'(bus.out_valid), 32'(m_stage != 0));
      chk("count", 32'(fifo_count), 32'(m_fifo.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef SPIKE_EVENT_DROP_CNT_EN
      chk("drop_count", 32'(drop_count), 32'(m_drops));
`endif
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL data: unexpected byte 0x%0h, none expected at %0t", bus.out_data, $time);
        end else begin
          chk("data", 32'(bus.out_data), 32'(exp_q[0]));
          if (bus.out_ready) begin
            got_q.push_back(bus.out_data);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("idle_data", 32'(bus.out_data), 32'd0);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    got_q.delete();
    max_cnt = 0;
  endtask

  task automatic check_frames(input string name, input int n, input logic [31:0] bytes);
    chk({name, "_len"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk(name, 32'(got_q[i]), (bytes >> (8 * (n - 1 - i))) & 32'hFF);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    cyc(3);

    // Single pre pulse at ts=2
    do_reset();
    enable = 1'b1; bus.out_ready = 1'b1;
    cyc(40);
    spike_pre = 1'b1; cyc(5); spike_pre = 1'b0;
    cyc(20);
    check_frames("pre_frame", 2, 32'h0000_A002);

    // Simultaneous edges at ts=0x123
    do_reset();
    for (int i = 0; i < 10000 && m_en != 32'h123 * PRESCALE + 4; i++) cyc(1);
    spike_pre = 1'b1; spike_post = 1'b1; cyc(3);
    spike_pre = 1'b0; spike_post = 1'b0; cyc(20);
    check_frames("both_frame", 2, 32'h0000_E223);
    chk("both_max_count", 32'(max_cnt), 32'd1);

    // Overflow with consumer stalled
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      spike_pre = 1'b1; cyc(1); spike_pre = 1'b0; cyc(1);
    end
    cyc(3);
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
`ifdef SPIKE_EVENT_DROP_CNT_EN
    chk("ovf_drops", 32'(drop_count), 32'd1);
`endif
    bus.out_ready = 1'b1;
    cyc(30);
    chk("ovf_frames", 32'(got_q.size()), 32'd18);
    for (int i = 0; i + 1 < got_q.size(); i += 2) begin
      chk("ovf_header", 32'(got_q[i]), 32'hA0);
      if (i >= 2) chk("ovf_order", 32'(got_q[i+1] >= got_q[i-1]), 32'd1);
    end

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      enable        = ($urandom_range(0, 15) != 0);
      spike_pre     = ($urandom_range(0, 3) == 0);
      spike_post    = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cyc(1);
    end
    spike_pre = 1'b0; spike_post = 1'b0; bus.out_ready = 1'b1; enable = 1'b1;
    cyc(40);

    // Timestamp wrap with a post edge colliding with the marker write
    do_reset();
    for (int i = 0; i < 70000 && m_en != 4096 * PRESCALE; i++) cyc(1);
    spike_post = 1'b1; cyc(2); spike_post = 1'b0;
    cyc(20);
    check_frames("wrap_collide", 4, 32'hC000_8000);

    // Reset while the low byte is presented
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      spike_pre = 1'b1; cyc(1); spike_pre = 1'b0; cyc(1);
    end
    cyc(3);
    bus.out_ready = 1'b1; cyc(1); bus.out_ready = 1'b0;
    cyc(2);
    chk("in_lo_state", 32'({bus.out_valid, bus.out_data[7]}), 32'b10);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_data", 32'(bus.out_data), 32'd0);
    cyc(1);
    reset_n = 1'b1;
    got_q.delete();

    // Disabled: edges ignored and timestamp frozen
    enable = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      spike_pre = 1'b1; spike_post = 1'b1; cyc(2);
      spike_pre = 1'b0; spike_post = 1'b0; cyc(2);
    end
    cyc(5);
    chk("disabled_frames", 32'(got_q.size()), 32'd0);
    enable = 1'b1; spike_pre = 1'b1; cyc(2); spike_pre = 1'b0;
    cyc(20);
    check_frames("frozen_ts", 2, 32'h0000_A000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
